// File: rtl/prbs6_checker_if.sv
// rtl/prbs6_checker_if.sv - beat and status bundle between a PRBS6 source and its checker
interface prbs6_checker_if #(
  parameter int err_width_p = 8
);
  logic                   valid_i;
  logic [5:0]             data_i;
  logic                   clear_i;
  logic                   locked_o;
  logic                   err_o;
  logic                   zero_o;
  logic [err_width_p-1:0] err_count_o;
  logic                   sat_o;

  modport master (
    output valid_i, data_i, clear_i,
    input  locked_o, err_o, zero_o, err_count_o, sat_o
  );

  modport slave (
    input  valid_i, data_i, clear_i,
    output locked_o, err_o, zero_o, err_count_o, sat_o
  );
endinterface

// File: rtl/prbs6_checker.sv
// rtl/prbs6_checker.sv - locks onto an x^6+x^5+1 LFSR word stream and counts mismatches
module prbs6_checker #(
  parameter int lock_count_p   = 4,
  parameter int unlock_count_p = 3,
  parameter int err_width_p    = 8
) (
  input logic           clk_i,
  input logic           reset_n_i,
  prbs6_checker_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_e;

  localparam logic [err_width_p-1:0] CntMax = '1;

  state_e                 state_q;
  logic [5:0]             exp_q;
  logic [3:0]             run_q;
  logic                   locked_q;
  logic                   err_q;
  logic                   zero_q;
  logic                   sat_q;
  logic [err_width_p-1:0] cnt_q;

  logic [5:0]             next_data;
  logic [5:0]             next_exp;
  logic                   is_zero;
  logic                   is_match;
  logic                   err_hit;
  logic [4:0]             run_inc;
  logic [err_width_p-1:0] cnt_base;
  logic [err_width_p-1:0] cnt_inc;

  function automatic logic [5:0] lfsr_next(input logic [5:0] s);
    return {s[4:0], s[5] ^ s[4]};
  endfunction

  assign next_data = lfsr_next(bus.data_i);
  assign next_exp  = lfsr_next(exp_q);
  assign is_zero   = (bus.data_i == 6'd0);
  assign is_match  = (bus.data_i == exp_q);
  assign run_inc   = {1'b0, run_q} + 5'd1;
  assign err_hit   = bus.valid_i && (state_q == LOCKED) && !is_match;
  // Clear is applied before the increment so clear+error lands on a count of one.
  assign cnt_base  = bus.clear_i ? '0 : cnt_q;
  assign cnt_inc   = cnt_base + err_width_p'(1);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      exp_q    <= 6'd0;
      run_q    <= 4'd0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      zero_q   <= 1'b0;
      sat_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      err_q  <= err_hit;
      zero_q <= bus.valid_i && is_zero;

      cnt_q <= cnt_base;
      sat_q <= sat_q && !bus.clear_i;
      if (err_hit && (cnt_base != CntMax)) begin
        cnt_q <= cnt_inc;
        if (cnt_inc == CntMax) begin
          sat_q <= 1'b1;
        end
      end

      if (bus.valid_i) begin
        unique case (state_q)
          IDLE: begin
            if (!is_zero) begin
              exp_q   <= next_data;
              run_q   <= 4'd0;
              state_q <= ACQUIRE;
            end
          end
          ACQUIRE: begin
            exp_q <= next_data;
            if (is_zero) begin
              run_q   <= 4'd0;
              state_q <= IDLE;
            end else if (is_match) begin
              if (run_inc == 5'(lock_count_p)) begin
                run_q    <= 4'd0;
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end else begin
                run_q <= run_inc[3:0];
              end
            end else begin
              run_q <= 4'd0;
            end
          end
          LOCKED: begin
            // Free-run the prediction so a single corrupted word costs exactly one error.
            exp_q <= next_exp;
            if (!is_match) begin
              if (run_inc == 5'(unlock_count_p)) begin
                run_q    <= 4'd0;
                state_q  <= IDLE;
                locked_q <= 1'b0;
              end else begin
                run_q <= run_inc[3:0];
              end
            end else begin
              run_q <= 4'd0;
            end
          end
          default: begin
            state_q  <= IDLE;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.locked_o    = locked_q;
  assign bus.err_o       = err_q;
  assign bus.zero_o      = zero_q;
  assign bus.err_count_o = cnt_q;
  assign bus.sat_o       = sat_q;

endmodule

// File: tb/tb_prbs6_checker.sv
// tb/tb_prbs6_checker.sv - self-checking bench for prbs6_checker (default and 2-bit counter builds)
module tb_prbs6_checker;

  localparam int LOCK   = 4;
  localparam int UNLOCK = 3;
  localparam int MAX0   = 255;
  localparam int MAX1   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prbs6_checker_if #(.err_width_p(8)) b0 ();
  prbs6_checker_if #(.err_width_p(2)) b1 ();

  prbs6_checker #(.lock_count_p(LOCK), .unlock_count_p(UNLOCK), .err_width_p(8)) dut0 (
    .clk_i(clk), .reset_n_i(rst_n), .bus(b0.slave));
  prbs6_checker #(.lock_count_p(LOCK), .unlock_count_p(UNLOCK), .err_width_p(2)) dut1 (
    .clk_i(clk), .reset_n_i(rst_n), .bus(b1.slave));

  int checks = 0;
  int errors = 0;

  // reference model state: 0 idle, 1 acquire, 2 locked
  int m_state, m_exp, m_run, m_cnt0, m_cnt1, m_sat0, m_sat1, m_err, m_zero;
  int src;

  typedef struct {
    logic       v;
    logic [5:0] d;
    logic       c;
    int         lk;
    int         er;
    int         zr;
    int         cnt;
  } vec_t;
  vec_t tbl[22];

  function automatic int nxt(input int s);
    return ((s << 1) & 63) | (((s >> 5) ^ (s >> 4)) & 1);
  endfunction

  function automatic int corrupt(input int s);
    int c;
    c = s ^ 1;
    if (c == 0) c = 2;
    return c;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_exp = 0; m_run = 0;
    m_cnt0 = 0; m_cnt1 = 0; m_sat0 = 0; m_sat1 = 0; m_err = 0; m_zero = 0;
  endtask

  task automatic bump(inout int cnt, inout int sat, input int max, input int c);
    if (c) begin cnt = 0; sat = 0; end
    if (m_err && cnt < max) begin
      cnt++;
      if (cnt == max) sat = 1;
    end
  endtask

  task automatic model_step(input int v, input int d, input int c);
    m_err = 0;
    m_zero = 0;
    if (v) begin
      if (d == 0) m_zero = 1;
      if (m_state == 0) begin
        if (d != 0) begin m_exp = nxt(d); m_run = 0; m_state = 1; end
      end else if (m_state == 1) begin
        if (d == 0) begin
          m_run = 0; m_state = 0;
        end else begin
          if (d == m_exp) begin
            m_run++;
            if (m_run == LOCK) begin m_state = 2; m_run = 0; end
          end else m_run = 0;
          m_exp = nxt(d);
        end
      end else begin
        if (d != m_exp) begin
          m_err = 1;
          m_run++;
          if (m_run == UNLOCK) begin m_state = 0; m_run = 0; end
        end else m_run = 0;
        m_exp = nxt(m_exp);
      end
    end
    bump(m_cnt0, m_sat0, MAX0, c);
    bump(m_cnt1, m_sat1, MAX1, c);
  endtask

  task automatic compare_all();
    chk("locked0", b0.locked_o, m_state == 2);
    chk("err0", b0.err_o, m_err);
    chk("zero0", b0.zero_o, m_zero);
    chk("cnt0", b0.err_count_o, m_cnt0);
    chk("sat0", b0.sat_o, m_sat0);
    chk("locked1", b1.locked_o, m_state == 2);
    chk("cnt1", b1.err_count_o, m_cnt1);
    chk("sat1", b1.sat_o, m_sat1);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_locked"}, b0.locked_o | b1.locked_o, 0);
    chk({tag, "_err"}, b0.err_o | b1.err_o, 0);
    chk({tag, "_zero"}, b0.zero_o | b1.zero_o, 0);
    chk({tag, "_cnt"}, int'(b0.err_count_o) + int'(b1.err_count_o), 0);
    chk({tag, "_sat"}, b0.sat_o | b1.sat_o, 0);
  endtask

  task automatic cycle(input logic v, input logic [5:0] d, input logic c);
    b0.valid_i = v; b0.data_i = d; b0.clear_i = c;
    b1.valid_i = v; b1.data_i = d; b1.clear_i = c;
    @(posedge clk);
    #1;
    model_step(v, d, c);
    compare_all();
  endtask

  task automatic good();
    cycle(1'b1, 6'(src), 1'b0);
    src = nxt(src);
  endtask

  task automatic bad(input logic c);
    cycle(1'b1, 6'(corrupt(src)), c);
    src = nxt(src);
  endtask

  // async reset asserted and released between clock edges
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("rst");
    model_reset();
    #2 rst_n = 1'b1;
    src = 1;
  endtask

  initial begin
    b0.valid_i = 0; b0.data_i = 0; b0.clear_i = 0;
    b1.valid_i = 0; b1.data_i = 0; b1.clear_i = 0;
    model_reset();
    tbl[0]  = '{1'b1, 6'h01, 1'b0, 0, 0, 0, 0};
    tbl[1]  = '{1'b1, 6'h02, 1'b0, 0, 0, 0, 0};
    tbl[2]  = '{1'b1, 6'h04, 1'b0, 0, 0, 0, 0};
    tbl[3]  = '{1'b1, 6'h08, 1'b0, 0, 0, 0, 0};
    tbl[4]  = '{1'b1, 6'h10, 1'b0, 1, 0, 0, 0};
    tbl[5]  = '{1'b1, 6'h21, 1'b0, 1, 0, 0, 0};
    tbl[6]  = '{1'b1, 6'h03, 1'b0, 1, 0, 0, 0};
    tbl[7]  = '{1'b1, 6'h07, 1'b0, 1, 1, 0, 1};
    tbl[8]  = '{1'b1, 6'h0C, 1'b0, 1, 0, 0, 1};
    tbl[9]  = '{1'b0, 6'h3F, 1'b0, 1, 0, 0, 1};
    tbl[10] = '{1'b1, 6'h00, 1'b0, 1, 1, 1, 2};
    tbl[11] = '{1'b1, 6'h31, 1'b0, 1, 0, 0, 2};
    tbl[12] = '{1'b1, 6'h3F, 1'b0, 1, 1, 0, 3};
    tbl[13] = '{1'b1, 6'h3F, 1'b0, 1, 1, 0, 4};
    tbl[14] = '{1'b1, 6'h3F, 1'b0, 0, 1, 0, 5};
    tbl[15] = '{1'b1, 6'h01, 1'b0, 0, 0, 0, 5};
    tbl[16] = '{1'b1, 6'h02, 1'b0, 0, 0, 0, 5};
    tbl[17] = '{1'b1, 6'h04, 1'b0, 0, 0, 0, 5};
    tbl[18] = '{1'b1, 6'h08, 1'b0, 0, 0, 0, 5};
    tbl[19] = '{1'b1, 6'h10, 1'b0, 1, 0, 0, 5};
    tbl[20] = '{1'b1, 6'h21, 1'b1, 1, 0, 0, 0};
    tbl[21] = '{1'b1, 6'h3F, 1'b1, 1, 1, 0, 1};

    @(posedge clk);
    #1 check_zero_outputs("por");
    #2 rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].c);
      chk($sformatf("tbl%0d_locked", i), b0.locked_o, tbl[i].lk);
      chk($sformatf("tbl%0d_err", i), b0.err_o, tbl[i].er);
      chk($sformatf("tbl%0d_zero", i), b0.zero_o, tbl[i].zr);
      chk($sformatf("tbl%0d_cnt", i), b0.err_count_o, tbl[i].cnt);
    end

    // clean stream: 200 beats, no errors
    do_reset();
    for (int i = 0; i < 200; i++) good();
    chk("clean_locked", b0.locked_o, 1);
    chk("clean_cnt", b0.err_count_o, 0);

    // gaps keep lock, then a zero word while locked
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 2) == 0) cycle(1'b0, 6'($urandom_range(0, 63)), 1'b0);
      else good();
    end
    chk("gap_locked", b0.locked_o, 1);
    chk("gap_cnt", b0.err_count_o, 0);
    cycle(1'b1, 6'h00, 1'b0);
    src = nxt(src);
    chk("zero_err", b0.err_o, 1);
    chk("zero_zero", b0.zero_o, 1);
    chk("zero_cnt", b0.err_count_o, 1);

    // saturation of the 2-bit counter, runs kept below the unlock threshold
    do_reset();
    for (int i = 0; i < 5; i++) good();
    chk("sat_pre_locked", b1.locked_o, 1);
    for (int i = 0; i < 5; i++) begin bad(1'b0); good(); end
    chk("sat_cnt", b1.err_count_o, 3);
    chk("sat_flag", b1.sat_o, 1);
    chk("sat_cnt_wide", b0.err_count_o, 5);
    chk("sat_locked", b1.locked_o, 1);
    bad(1'b1);
    chk("clr_cnt", b1.err_count_o, 1);
    chk("clr_sat", b1.sat_o, 0);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      int r;
      logic c;
      r = $urandom_range(0, 99);
      c = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 3) == 0) cycle(1'b0, 6'($urandom_range(0, 63)), c);
      else if (r < 4) begin cycle(1'b1, 6'h00, c); src = nxt(src); end
      else if (r < 10) bad(c);
      else begin
        cycle(1'b1, 6'(src), c);
        src = nxt(src);
      end
    end

    // reset while locked, then minimum lock time
    do_reset();
    for (int i = 0; i < 8; i++) good();
    chk("mid_locked", b0.locked_o, 1);
    do_reset();
    for (int i = 0; i < 4; i++) good();
    chk("relock_early", b0.locked_o, 0);
    good();
    chk("relock_on_time", b0.locked_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
